// File: rtl/reply_scheduler.sv
// reply_scheduler
//   Transponder timing stage between the receive strobe and the tx burst
//   generator. Received-symbol strobes are grouped into a burst. The burst
//   closes after GAP idle cycles. A burst with at least MIN_HITS strobes
//   schedules a one-cycle reply strobe REPLY_DLY cycles after the burst
//   midpoint. The reply strobe is followed by a TX_LEN-cycle tx_en window.
//
// Ports
//   clk        system clock
//   rst        synchronous active-high reset
//   rx_stb     one-cycle receive strobe (may repeat on consecutive cycles)
//   tx_stb     one-cycle reply strobe
//   tx_en      reply window, gates the receive path
//   busy       high whenever the scheduler is not idle
//   late       reply fired past its target; held until the next burst starts
//   err        one-cycle pulse on burst timer overflow
//   burst_len  first-to-last strobe distance of the last accepted burst
//   hit_cnt    strobe count of the last accepted burst (saturating)
module reply_scheduler #(
    parameter int unsigned CW        = 16,
    parameter int unsigned HW        = 8,
    parameter int unsigned GAP       = 256,
    parameter int unsigned MIN_HITS  = 4,
    parameter int unsigned REPLY_DLY = 1024,
    parameter int unsigned TX_LEN    = 4800
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rx_stb,
    output logic          tx_stb,
    output logic          tx_en,
    output logic          busy,
    output logic          late,
    output logic          err,
    output logic [CW-1:0] burst_len,
    output logic [HW-1:0] hit_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BURST,
        S_WAIT,
        S_TX
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic [CW-1:0] t;
    logic [CW-1:0] last_t;
    logic [CW-1:0] target;
    logic [HW-1:0] hits;

    logic          close_hit;
    logic          enough;
    logic          t_max;
    logic          fire;
    logic          tx_done;

    always_comb begin
        close_hit = !rx_stb && ((t - last_t) == CW'(GAP));
        enough    = (hits >= HW'(MIN_HITS));
        t_max     = (t == '1);
        fire      = (t >= target);
        tx_done   = (t == CW'(TX_LEN));
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a closing burst takes priority over timer overflow
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (rx_stb) begin
                    state_nxt = S_BURST;
                end
            end
            S_BURST: begin
                if (close_hit) begin
                    state_nxt = enough ? S_WAIT : S_IDLE;
                end else if (t_max) begin
                    state_nxt = S_IDLE;
                end
            end
            S_WAIT: begin
                if (fire) begin
                    state_nxt = S_TX;
                end
            end
            S_TX: begin
                if (tx_done) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath and registered outputs. The timer t is reused in TX to count
    // tx_en cycles, restarting at 1 on the first tx_en cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            t         <= '0;
            last_t    <= '0;
            target    <= '0;
            hits      <= '0;
            tx_stb    <= 1'b0;
            tx_en     <= 1'b0;
            busy      <= 1'b0;
            late      <= 1'b0;
            err       <= 1'b0;
            burst_len <= '0;
            hit_cnt   <= '0;
        end else begin
            tx_stb <= 1'b0;
            err    <= 1'b0;
            busy   <= (state_nxt != S_IDLE);
            case (state)
                S_IDLE: begin
                    if (rx_stb) begin
                        t      <= CW'(1);
                        last_t <= '0;
                        hits   <= HW'(1);
                        late   <= 1'b0;
                    end
                end
                S_BURST: begin
                    t <= t + 1'b1;
                    if (rx_stb) begin
                        last_t <= t;
                        if (hits != '1) begin
                            hits <= hits + 1'b1;
                        end
                    end
                    if (close_hit) begin
                        if (enough) begin
                            burst_len <= last_t;
                            hit_cnt   <= hits;
                            target    <= (last_t >> 1) + CW'(REPLY_DLY);
                        end
                    end else if (t_max) begin
                        err <= 1'b1;
                    end
                end
                S_WAIT: begin
                    t <= t + 1'b1;
                    if (fire) begin
                        tx_stb <= 1'b1;
                        tx_en  <= 1'b1;
                        late   <= (t > target);
                        t      <= CW'(1);
                    end
                end
                S_TX: begin
                    t <= t + 1'b1;
                    if (tx_done) begin
                        tx_en <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_reply_scheduler.sv
// Directed bench for reply_scheduler. dut_a uses the default parameters.
// dut_b uses a narrow timer, a narrow hit counter, a short reply delay and a
// short tx window, so that overflow, saturation and late replies are quick.
module tb_reply_scheduler;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        rx_a;
    logic        rx_b;

    logic        a_tx_stb, a_tx_en, a_busy, a_late, a_err;
    logic [15:0] a_burst_len;
    logic [7:0]  a_hit_cnt;

    logic        b_tx_stb, b_tx_en, b_busy, b_late, b_err;
    logic [11:0] b_burst_len;
    logic [2:0]  b_hit_cnt;

    reply_scheduler dut_a (
        .clk       (clk),
        .rst       (rst),
        .rx_stb    (rx_a),
        .tx_stb    (a_tx_stb),
        .tx_en     (a_tx_en),
        .busy      (a_busy),
        .late      (a_late),
        .err       (a_err),
        .burst_len (a_burst_len),
        .hit_cnt   (a_hit_cnt)
    );

    reply_scheduler #(
        .CW        (12),
        .HW        (3),
        .REPLY_DLY (16),
        .TX_LEN    (20)
    ) dut_b (
        .clk       (clk),
        .rst       (rst),
        .rx_stb    (rx_b),
        .tx_stb    (b_tx_stb),
        .tx_en     (b_tx_en),
        .busy      (b_busy),
        .late      (b_late),
        .err       (b_err),
        .burst_len (b_burst_len),
        .hit_cnt   (b_hit_cnt)
    );

    int tests = 0;
    int fails = 0;

    bit sel;   // 0 drives/observes dut_a, 1 drives/observes dut_b

    // Stimulus plan for one run (cycle k counted from C0 = 0)
    int cfg_period, cfg_last, cfg_from2, cfg_to2, cfg_extra, cfg_rst, cfg_probe;

    // Observations gathered over one run
    int first_stb, n_stb, first_en, last_en, n_en;
    int busy_rise, busy_fall, err_at, n_err;
    logic probe_busy, probe_late;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cfg_clear();
        cfg_period = 10;
        cfg_last   = -1;
        cfg_from2  = 0;
        cfg_to2    = -1;
        cfg_extra  = -1;
        cfg_rst    = -1;
        cfg_probe  = -1;
    endtask

    function automatic bit stb_at(input int k);
        return ((k % cfg_period) == 0 && k <= cfg_last) ||
               (k >= cfg_from2 && k <= cfg_to2 && ((k - cfg_from2) % 50) == 0) ||
               (k == cfg_extra);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        logic stb, en, bz, er, lt;
        first_stb = -1; n_stb = 0; first_en = -1; last_en = -1; n_en = 0;
        busy_rise = -1; busy_fall = -1; err_at = -1; n_err = 0;
        probe_busy = 1'bx; probe_late = 1'bx;
        for (int k = 0; k < n; k++) begin
            rx_a = !sel && stb_at(k);
            rx_b = sel && stb_at(k);
            rst  = (k == cfg_rst);
            stb = sel ? b_tx_stb : a_tx_stb;
            en  = sel ? b_tx_en  : a_tx_en;
            bz  = sel ? b_busy   : a_busy;
            er  = sel ? b_err    : a_err;
            lt  = sel ? b_late   : a_late;
            if (stb) begin
                if (first_stb < 0) first_stb = k;
                n_stb++;
            end
            if (en) begin
                if (first_en < 0) first_en = k;
                last_en = k;
                n_en++;
            end
            if (bz && busy_rise < 0) busy_rise = k;
            if (!bz && busy_rise >= 0 && busy_fall < 0) busy_fall = k;
            if (er) begin
                if (err_at < 0) err_at = k;
                n_err++;
            end
            if (k == cfg_probe) begin
                probe_busy = bz;
                probe_late = lt;
            end
            tick();
        end
        rx_a = 1'b0;
        rx_b = 1'b0;
        rst  = 1'b0;
    endtask

    initial begin
        rst  = 1'b1;
        rx_a = 1'b0;
        rx_b = 1'b0;
        sel  = 1'b0;
        cfg_clear();
        tick(); tick(); tick();
        rst = 1'b0;
        tick();

        // Reset state
        chk("rst_a_flags", {a_tx_stb, a_tx_en, a_busy, a_late, a_err}, 0);
        chk("rst_a_len",   a_burst_len, 0);
        chk("rst_a_hits",  a_hit_cnt, 0);
        chk("rst_b_flags", {b_tx_stb, b_tx_en, b_busy, b_late, b_err}, 0);
        chk("rst_b_len",   b_burst_len, 0);
        chk("rst_b_hits",  b_hit_cnt, 0);

        // Test 1: 11 strobes 0..100, on-time reply at 50+1024+1
        sel = 1'b0; cfg_clear(); cfg_last = 100;
        run(6000);
        chk("t1_stb_at",    first_stb, 1075);
        chk("t1_stb_n",     n_stb, 1);
        chk("t1_en_first",  first_en, 1075);
        chk("t1_en_last",   last_en, 5874);
        chk("t1_en_n",      n_en, 4800);
        chk("t1_busy_rise", busy_rise, 1);
        chk("t1_busy_fall", busy_fall, 5875);
        chk("t1_err_n",     n_err, 0);
        chk("t1_len",       a_burst_len, 100);
        chk("t1_hits",      a_hit_cnt, 11);
        chk("t1_late",      a_late, 0);

        // Test 2: 3 strobes at 0,5,9 -> rejected, closes at t=265
        cfg_clear(); cfg_period = 5; cfg_last = 5; cfg_extra = 9;
        run(300);
        chk("t2_stb_n",     n_stb, 0);
        chk("t2_en_n",      n_en, 0);
        chk("t2_busy_fall", busy_fall, 266);
        chk("t2_len",       a_burst_len, 100);
        chk("t2_hits",      a_hit_cnt, 11);

        // Test 5: strobes during TX ignored; strobe in first IDLE cycle restarts
        cfg_clear(); cfg_last = 100; cfg_from2 = 1075; cfg_to2 = 5874;
        cfg_extra = 5875; cfg_probe = 5876;
        run(6200);
        chk("t5_stb_at",    first_stb, 1075);
        chk("t5_stb_n",     n_stb, 1);
        chk("t5_en_first",  first_en, 1075);
        chk("t5_en_last",   last_en, 5874);
        chk("t5_en_n",      n_en, 4800);
        chk("t5_busy_fall", busy_fall, 5875);
        chk("t5_restart",   probe_busy, 1);
        chk("t5_len",       a_burst_len, 100);
        chk("t5_hits",      a_hit_cnt, 11);
        chk("t5_idle",      a_busy, 0);

        // Test 6: reset at C0+600 aborts the reply
        cfg_clear(); cfg_last = 100; cfg_rst = 600;
        run(700);
        chk("t6_stb_n",     n_stb, 0);
        chk("t6_en_n",      n_en, 0);
        chk("t6_busy_fall", busy_fall, 601);
        chk("t6_len",       a_burst_len, 0);
        chk("t6_hits",      a_hit_cnt, 0);

        // Test 6b: 12 strobes 0..110 after reset -> reply at 55+1024+1
        cfg_clear(); cfg_last = 110;
        run(6000);
        chk("t6b_stb_at",   first_stb, 1080);
        chk("t6b_stb_n",    n_stb, 1);
        chk("t6b_en_last",  last_en, 5879);
        chk("t6b_en_n",     n_en, 4800);
        chk("t6b_len",      a_burst_len, 110);
        chk("t6b_hits",     a_hit_cnt, 12);
        chk("t6b_late",     a_late, 0);

        // Test 3 (dut_b): target 66 already passed at first WAIT cycle -> late
        sel = 1'b1; cfg_clear(); cfg_last = 100;
        run(500);
        chk("t3_stb_at",    first_stb, 358);
        chk("t3_stb_n",     n_stb, 1);
        chk("t3_en_first",  first_en, 358);
        chk("t3_en_n",      n_en, 20);
        chk("t3_busy_fall", busy_fall, 378);
        chk("t3_late",      b_late, 1);
        chk("t3_len",       b_burst_len, 100);
        chk("t3_hits_sat",  b_hit_cnt, 7);

        // Exactly MIN_HITS strobes are accepted; late clears at burst start
        cfg_clear(); cfg_last = 30; cfg_probe = 1;
        run(400);
        chk("mh_late_clr",  probe_late, 0);
        chk("mh_busy_c1",   probe_busy, 1);
        chk("mh_stb_at",    first_stb, 288);
        chk("mh_en_n",      n_en, 20);
        chk("mh_busy_fall", busy_fall, 308);
        chk("mh_late",      b_late, 1);
        chk("mh_len",       b_burst_len, 30);
        chk("mh_hits",      b_hit_cnt, 4);

        // Test 4 (dut_b, 12-bit timer): overflow err at C0+4096, then restart
        cfg_clear(); cfg_period = 100; cfg_last = 4300; cfg_probe = 4101;
        run(4700);
        chk("t4_err_at",    err_at, 4096);
        chk("t4_err_n",     n_err, 1);
        chk("t4_stb_n",     n_stb, 0);
        chk("t4_en_n",      n_en, 0);
        chk("t4_busy_fall", busy_fall, 4096);
        chk("t4_restart",   probe_busy, 1);
        chk("t4_len",       b_burst_len, 30);
        chk("t4_hits",      b_hit_cnt, 4);
        chk("t4_late",      b_late, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
